// File: rtl/trigger_generator.sv
// Programmable TRG source for the trigger switch generator input.
// Emits single-tick TRG pulses on the sync grid, either periodic or LFSR-random, with an optional count limit.
module trigger_generator #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sync,
  input  logic                 enable,
  input  logic                 mode,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic [CNT_WIDTH-1:0] rate,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [4:0]           dst,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] trg_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0]          LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0]          LFSR_SEED = 32'h0000_0001;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO   = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t                 state_q;
  logic                   mode_q;
  logic [CNT_WIDTH-1:0]   period_q;
  logic [CNT_WIDTH-1:0]   limit_q;
  logic [CNT_WIDTH-1:0]   tick_cnt_q;
  logic [31:0]            lfsr_q;
  logic                   trg_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CNT_WIDTH-1:0]   trg_count_q;

  logic [31:0]            lfsr_d;
  logic [CNT_WIDTH-1:0]   lfsr_cmp;
  logic [CNT_WIDTH-1:0]   period_clamped;
  logic [CNT_WIDTH-1:0]   trg_count_d;
  logic                   period_hit;
  logic                   rand_hit;
  logic                   fire;
  logic                   limit_hit;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  // The LFSR is always 32 bits; the rate comparison sees only CNT_WIDTH of it.
  generate
    if (CNT_WIDTH <= 32) begin : g_cmp_narrow
      assign lfsr_cmp = lfsr_d[CNT_WIDTH-1:0];
    end else begin : g_cmp_wide
      assign lfsr_cmp = {{(CNT_WIDTH-32){1'b0}}, lfsr_d};
    end
  endgenerate

  assign period_clamped = (period < CNT_TWO) ? CNT_TWO : period;
  assign period_hit     = (tick_cnt_q == (period_q - CNT_ONE));
  // trg_q is the previous tick's TRG, which enforces the minimum spacing of 2.
  assign rand_hit       = (lfsr_cmp < rate) && !trg_q;
  assign fire           = mode_q ? rand_hit : period_hit;
  assign trg_count_d    = (trg_count_q == CNT_MAX) ? trg_count_q : (trg_count_q + CNT_ONE);
  assign limit_hit      = (limit_q != '0) && (trg_count_d == limit_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      period_q    <= CNT_TWO;
      limit_q     <= '0;
      tick_cnt_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      trg_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trg_count_q <= '0;
    end else if (sync) begin
      case (state_q)
        ST_IDLE: begin
          trg_q <= 1'b0;
          if (enable) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            mode_q      <= mode;
            period_q    <= period_clamped;
            limit_q     <= limit;
            tick_cnt_q  <= '0;
            lfsr_q      <= LFSR_SEED;
            trg_count_q <= '0;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            trg_q   <= 1'b0;
          end else begin
            tick_cnt_q <= period_hit ? '0 : (tick_cnt_q + CNT_ONE);
            if (mode_q) begin
              lfsr_q <= lfsr_d;
            end
            trg_q <= fire;
            if (fire) begin
              trg_count_q <= trg_count_d;
              if (limit_hit) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          trg_q <= 1'b0;
          if (!enable) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          trg_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dst       = {3'b000, trg_q, 1'b0};
  assign busy      = busy_q;
  assign done      = done_q;
  assign trg_count = trg_count_q;

endmodule

// File: tb/tb_trigger_generator.sv
// Self-checking bench for trigger_generator: directed vector table, hand sequences,
// and randomized stimulus against a tick-level reference model.
module tb_trigger_generator;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         sync;
  logic         enable;
  logic         mode;
  logic [W-1:0] period;
  logic [W-1:0] rate;
  logic [W-1:0] limit;
  logic [4:0]   dst;
  logic         busy;
  logic         done;
  logic [W-1:0] trg_count;

  int checks   = 0;
  int failures = 0;

  trigger_generator #(.CNT_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .enable    (enable),
    .mode      (mode),
    .period    (period),
    .rate      (rate),
    .limit     (limit),
    .dst       (dst),
    .busy      (busy),
    .done      (done),
    .trg_count (trg_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; one sync-qualified posedge, returns at the following negedge.
  task automatic tick();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  // ---------------- reference model: one call per sync tick ----------------
  bit          m_run, m_done, m_mode, m_prev;
  logic [31:0] m_p, m_lim, m_cnt, m_lfsr;
  longint      m_k;
  logic [4:0]  m_dst;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_mode = 0; m_prev = 0;
    m_p = 2; m_lim = 0; m_cnt = 0; m_lfsr = 1; m_k = 0; m_dst = 0;
  endtask

  task automatic model_tick();
    bit fire;
    if (!m_run && !m_done) begin
      m_dst = 0;
      if (enable) begin
        m_run = 1; m_mode = mode; m_p = (period < 2) ? 32'd2 : period;
        m_lim = limit; m_k = 0; m_cnt = 0; m_lfsr = 1; m_prev = 0;
      end
    end else if (m_done) begin
      m_dst = 0;
      if (!enable) m_done = 0;
    end else if (!enable) begin
      m_run = 0; m_dst = 0; m_prev = 0;
    end else begin
      m_k++;
      if (!m_mode) begin
        fire = ((m_k % longint'(m_p)) == 0);
      end else begin
        m_lfsr = lfsr_next(m_lfsr);
        fire = (m_lfsr < rate) && !m_prev;
      end
      m_prev = fire;
      m_dst  = fire ? 5'b00010 : 5'b00000;
      if (fire) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (m_lim != 0 && m_cnt == m_lim) begin
          m_run = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".dst"},  W'(dst),  W'(m_dst));
    chk({tag, ".busy"}, W'(busy), W'(m_run));
    chk({tag, ".done"}, W'(done), W'(m_done));
    chk({tag, ".cnt"},  trg_count, m_cnt);
  endtask

  task automatic step_cmp(input string tag);
    model_tick();
    tick();
    cmp_model(tag);
  endtask

  task automatic apply_reset();
    enable = 0; sync = 0; mode = 0; period = 0; rate = 0; limit = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         en;
    logic [W-1:0] per;
    logic [W-1:0] lim;
    int           n;
    logic [4:0]   e_dst;
    logic         e_busy;
    logic         e_done;
    logic [W-1:0] e_cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  initial begin
    int fires;
    logic [31:0] all_ones;
    all_ones = '1;

    // Clamp/limit/restart sequence, then abort sequence with period 4.
    vt[0]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00000, 1'b1, 1'b0, 32'd0};
    vt[1]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00000, 1'b1, 1'b0, 32'd0};
    vt[2]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00010, 1'b1, 1'b0, 32'd1};
    vt[3]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00000, 1'b1, 1'b0, 32'd1};
    vt[4]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00010, 1'b1, 1'b0, 32'd2};
    vt[5]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00000, 1'b1, 1'b0, 32'd2};
    vt[6]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00010, 1'b0, 1'b1, 32'd3};
    vt[7]  = '{1'b1, 32'd0, 32'd3, 5, 5'b00000, 1'b0, 1'b1, 32'd3};
    vt[8]  = '{1'b0, 32'd0, 32'd3, 1, 5'b00000, 1'b0, 1'b0, 32'd3};
    vt[9]  = '{1'b1, 32'd0, 32'd3, 1, 5'b00000, 1'b1, 1'b0, 32'd0};
    vt[10] = '{1'b1, 32'd7, 32'd1, 2, 5'b00010, 1'b1, 1'b0, 32'd1};
    vt[11] = '{1'b0, 32'd7, 32'd1, 1, 5'b00000, 1'b0, 1'b0, 32'd1};
    vt[12] = '{1'b1, 32'd4, 32'd0, 1, 5'b00000, 1'b1, 1'b0, 32'd0};
    vt[13] = '{1'b1, 32'd4, 32'd0, 4, 5'b00010, 1'b1, 1'b0, 32'd1};
    vt[14] = '{1'b1, 32'd4, 32'd0, 3, 5'b00000, 1'b1, 1'b0, 32'd1};
    vt[15] = '{1'b0, 32'd4, 32'd0, 1, 5'b00000, 1'b0, 1'b0, 32'd1};
    vt[16] = '{1'b0, 32'd4, 32'd0, 2, 5'b00000, 1'b0, 1'b0, 32'd1};

    reset = 1'b0; sync = 0; enable = 0; mode = 0; period = 0; rate = 0; limit = 0;
    apply_reset();

    chk("reset.dst",  W'(dst),  '0);
    chk("reset.busy", W'(busy), '0);
    chk("reset.done", W'(done), '0);
    chk("reset.cnt",  trg_count, '0);

    for (int v = 0; v < NV; v++) begin
      enable = vt[v].en; period = vt[v].per; limit = vt[v].lim; mode = 1'b0;
      for (int t = 0; t < vt[v].n; t++) tick();
      chk($sformatf("vec%0d.dst", v),  W'(dst),  W'(vt[v].e_dst));
      chk($sformatf("vec%0d.busy", v), W'(busy), W'(vt[v].e_busy));
      chk($sformatf("vec%0d.done", v), W'(done), W'(vt[v].e_done));
      chk($sformatf("vec%0d.cnt", v),  trg_count, vt[v].e_cnt);
      $display("vec %0d: en=%0b per=%0d lim=%0d ticks=%0d -> dst=%b busy=%0b done=%0b cnt=%0d",
               v, vt[v].en, vt[v].per, vt[v].lim, vt[v].n, dst, busy, done, trg_count);
    end

    // Periodic basic: sync every 4 clk, period 5, each pulse held for 4 clk.
    apply_reset();
    period = 5; limit = 0; mode = 0; enable = 1;
    tick();
    repeat (3) @(negedge clk);
    chk("per.enter.busy", W'(busy), 1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("per.k%0d.g%0d.dst", k, g), W'(dst), (k % 5 == 0) ? 32'd2 : 32'd0);
        @(negedge clk);
      end
    end
    chk("per.cnt", trg_count, 3);
    $display("periodic basic: 15 ticks done, trg_count=%0d", trg_count);

    // Reset mid-pulse clears outputs asynchronously; release waits for a sync tick.
    apply_reset();
    period = 2; enable = 1;
    repeat (3) tick();
    chk("rst.pre.dst", W'(dst), 2);
    chk("rst.pre.cnt", trg_count, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst.mid.dst",  W'(dst),  0);
    chk("rst.mid.busy", W'(busy), 0);
    chk("rst.mid.done", W'(done), 0);
    chk("rst.mid.cnt",  trg_count, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk($sformatf("rst.nosync%0d.busy", g), W'(busy), 0);
    end
    tick();
    chk("rst.after.busy", W'(busy), 1);
    $display("reset mid-pulse sequence done");

    // Random mode: rate 0, then all-ones, then randomized rates with a sync gap.
    apply_reset();
    mode = 1; rate = 0; limit = 0; period = 0; enable = 1;
    step_cmp("rnd.enter");
    fires = 0;
    for (int t = 0; t < 1000; t++) begin
      step_cmp("rnd.r0");
      if (dst[1]) fires++;
    end
    chk("rnd.r0.fires", W'(fires), 0);
    chk("rnd.r0.cnt", trg_count, 0);
    rate = all_ones;
    fires = 0;
    for (int t = 0; t < 200; t++) begin
      step_cmp("rnd.max");
      chk("rnd.max.alt", W'(dst), (t % 2 == 0) ? 32'd2 : 32'd0);
      if (dst[1]) fires++;
    end
    chk("rnd.max.fires", W'(fires), 100);
    $display("random: rate=0 and rate=max phases done, trg_count=%0d", trg_count);
    for (int t = 0; t < 10000; t++) begin
      if (t % 100 == 0) rate = $urandom;
      if (t == 5000) begin
        for (int g = 0; g < 50; g++) begin
          @(negedge clk);
          cmp_model("rnd.gate");
        end
      end
      step_cmp("rnd.seq");
    end
    $display("random: 10000-tick sequence done, trg_count=%0d", trg_count);

    // Fully random stimulus: enable toggles, mid-run config changes, limits.
    apply_reset();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) begin
        mode   = 1'($urandom);
        period = $urandom_range(0, 6);
        limit  = $urandom_range(0, 5);
        rate   = $urandom;
      end
      step_cmp("mix");
    end
    $display("mixed random: 3000 ticks done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
